// File: rtl/keccak_padder.sv
// Byte-stream front-end for the keccak sponge: packs bytes into rate blocks, applies
// the domain suffix and pad10*1, and hands blocks over valid/ready. Option: KECCAK_PAD_SHAKE_EN.
module keccak_padder #(
    parameter int D  = 112,
    parameter int B  = 1600,
    parameter int RW = B - 2 * D
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_last,
    input  logic          in_null,
`ifdef KECCAK_PAD_SHAKE_EN
    input  logic          shake,
`endif
    output logic [RW-1:0] block,
    output logic          block_valid,
    input  logic          block_ready,
    output logic          block_last,
    output logic [1:0]    dbg_state
);
    localparam int RBYTES = RW / 8;
    localparam int CW     = $clog2(RBYTES);
    localparam int TOP    = 8 * (RBYTES - 1);

    // Handshakes: a transfer happens on a rising clk edge when valid && ready are
    // both high; valid-side payload is held stable until that edge.
    typedef enum logic [1:0] {S_FILL = 2'd0, S_EMIT = 2'd1, S_EMIT_PAD = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   buf_q, buf_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            last_q, last_d;
    logic            pad_q, pad_d;
    logic [7:0]      suffix;
    logic            data_xfer;
    logic            blk_xfer;

`ifdef KECCAK_PAD_SHAKE_EN
    logic shake_q, shake_d;
    logic active_q, active_d;
    // The mode is latched on the first byte and holds until the final block leaves.
    assign suffix = (active_q ? shake_q : shake) ? 8'h1F : 8'h06;
`else
    assign suffix = 8'h06;
`endif

    // in_null without in_last is dropped, so it never counts as a data transfer.
    assign data_xfer = (state_q == S_FILL) && !reset && in_valid && !(in_null && !in_last);
    assign blk_xfer  = block_valid && block_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FILL;
            buf_q   <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            pad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            pad_q   <= pad_d;
        end
    end

`ifdef KECCAK_PAD_SHAKE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            shake_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            shake_q  <= shake_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        shake_d  = shake_q;
        active_d = active_q;
        if (data_xfer && !active_q) begin
            shake_d  = shake;
            active_d = 1'b1;
        end
        if (blk_xfer && block_last) active_d = 1'b0;
    end
`endif

    // Datapath: byte writes, suffix/pad insertion, and clearing after a block leaves.
    always_comb begin
        buf_d  = buf_q;
        cnt_d  = cnt_q;
        last_d = last_q;
        pad_d  = pad_q;
        if (data_xfer) begin
            last_d = 1'b0;
            if (!in_null) begin
                buf_d[8*int'(cnt_q) +: 8] = in_data;
                cnt_d = (int'(cnt_q) == RBYTES - 1) ? '0 : cnt_q + CW'(1);
            end
            if (in_last) begin
                if (in_null) begin
                    buf_d[8*int'(cnt_q) +: 8] = suffix;
                    buf_d[TOP +: 8] = buf_d[TOP +: 8] | 8'h80;
                    last_d = 1'b1;
                end else if (int'(cnt_q) == RBYTES - 1) begin
                    pad_d = 1'b1;
                end else begin
                    buf_d[8*(int'(cnt_q) + 1) +: 8] = suffix;
                    buf_d[TOP +: 8] = buf_d[TOP +: 8] | 8'h80;
                    last_d = 1'b1;
                end
            end
        end
        if (blk_xfer) begin
            buf_d  = '0;
            cnt_d  = '0;
            last_d = 1'b0;
            if (state_q == S_EMIT_PAD) pad_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FILL:     if (data_xfer && (in_last || int'(cnt_q) == RBYTES - 1)) state_d = S_EMIT;
            S_EMIT:     if (blk_xfer) state_d = pad_q ? S_EMIT_PAD : S_FILL;
            S_EMIT_PAD: if (blk_xfer) state_d = S_FILL;
            default:    state_d = S_FILL;
        endcase
    end

    always_comb begin
        in_ready    = (state_q == S_FILL) && !reset;
        block_valid = (state_q != S_FILL);
        block_last  = ((state_q == S_EMIT) && last_q) || (state_q == S_EMIT_PAD);
        block       = buf_q;
        if (state_q == S_EMIT_PAD) begin
            block          = '0;
            block[7:0]     = suffix;
            block[TOP +: 8] = 8'h80;
        end
        dbg_state   = state_q;
    end

    a_null_needs_last: assert property (@(posedge clk) disable iff (reset)
        !(in_valid && in_null && !in_last));
endmodule

// File: doc/keccak_padder.md
Name: keccak_padder

Overview:
- Message front-end for the keccak sponge core.
- Accepts a byte stream with a last-byte marker and packs the bytes into r-bit rate blocks.
- Applies FIPS 202 domain suffix plus pad10*1 padding, and presents each block to the core over a valid/ready handshake.
- The core's enable is driven from block_valid && block_ready; block_last tells downstream logic that the digest is valid one cycle after that block's transfer.

Parameters:
- d, 112: digest length in bits; capacity c = 2*d.
- b, 1600: permutation width in bits.
- r, b-2*d: rate in bits; must be a multiple of 8. R = r/8 bytes per block (172 at default).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_data  input  8  message byte.
- in_valid  input  1  in_data/in_last/in_null valid.
- in_ready  output  1  padder can accept a byte this cycle.
- in_last  input  1  final transfer of the message.
- in_null  input  1  with in_last: terminate the message without a data byte (empty message, or a message already ended).
- block  output  r  rate block; byte k at block[8k +: 8].
- block_valid  output  1  block is presented.
- block_ready  input  1  core consumes block (core enable).
- block_last  output  1  current block is the final padded block.

Behaviour:
- Reset values: in_ready=0 during the reset cycle and 1 after it; block_valid=0; block_last=0; block=0; byte counter=0; state=FILL. Reset mid-message discards all partial data.
- States: FILL, EMIT, EMIT_PAD.
- Byte counter cnt runs 0..R-1, width $clog2(R).
- FILL:
  - in_ready=1. A transfer occurs when in_valid && in_ready; each data transfer writes block byte cnt and increments cnt.
  - Transfer with !in_last and cnt==R-1 -> EMIT, block_last=0.
  - Transfer with in_last and !in_null: byte written at cnt.
    - cnt<R-1: suffix written at cnt+1; byte R-1 ORed with 0x80 in the same cycle; -> EMIT, block_last=1. If cnt+1==R-1, byte R-1 = suffix|0x80 = 0x86.
    - cnt==R-1: block full, no pad room; -> EMIT, block_last=0; pad_pending set.
  - Transfer with in_last && in_null: suffix written at cnt, byte R-1 |= 0x80; -> EMIT, block_last=1. If cnt==R-1, byte R-1 = 0x86.
- EMIT:
  - in_ready=0, block_valid=1. block and block_last are held stable until block_ready.
  - On block_valid && block_ready: buffer cleared to 0, cnt=0, block_valid=0.
  - Next state: pad_pending ? EMIT_PAD : FILL.
- EMIT_PAD:
  - Entered only via pad_pending.
  - block = suffix at byte 0, 0x80 at byte R-1, all else 0; block_last=1, block_valid=1, in_ready=0.
  - On transfer: clear pad_pending and buffer -> FILL.
- Latency: block_valid asserts the cycle after the byte transfer that completes or terminates a block. Sustained throughput is R bytes per R+1 cycles when block_ready is held high.
- A new message may start in the FILL cycle immediately after the last block's transfer. The core state is not reset by this block.
- block_ready while block_valid=0 is ignored.
- in_null without in_last is illegal. It must be flagged by an assertion and is ignored (no write, no count change).
- suffix = 0x06 (SHA3).

Optional Feature:
- Macro KECCAK_PAD_SHAKE_EN.
- Defined: adds input port shake (1 bit), sampled on the first transfer of each message and held until block_last transfers. suffix = shake ? 0x1F : 0x06.
- Undefined: port absent; suffix fixed at 0x06.

Test Plan:
- Empty message (in_last=1, in_null=1 at cnt=0) -> one block, byte0=0x06, byte171=0x80, rest 0, block_last=1.
- "abc" (0x61,0x62,0x63, last on 0x63) -> bytes0..2=61 62 63, byte3=0x06, byte171=0x80, block_last=1; block_valid exactly one cycle after the 0x63 transfer.
- 171 bytes of 0xA5 -> single block, bytes0..170=0xA5, byte171=0x86, block_last=1.
- 172 bytes of 0xA5 -> block 1 all 0xA5 with block_last=0, then block 2 with byte0=0x06, byte171=0x80, block_last=1; in_ready=0 throughout both emits.
- Backpressure: block_ready held 0 for 5 cycles in EMIT -> block, block_valid, block_last stable; in_ready=0; a single transfer occurs when block_ready rises.
- Reset asserted after 50 bytes -> in_ready=1 and block_valid=0 after reset; next "abc" produces the same block as the "abc" scenario with no residue from the aborted message.
